// File: rtl/bus_mux_pipe.sv
// bus_mux_pipe: registered N:1 channel mux behind a valid/ready handshake.
// Selects one K-bit channel with a one-hot (SEL_MODE=0) or binary (SEL_MODE=1)
// select. Illegal selects return zero data and are flagged per beat. A sticky
// flag and a saturating counter record them until err_clr.
module bus_mux_pipe #(
  parameter int unsigned K        = 16,
  parameter int unsigned N        = 8,
  parameter int unsigned SEL_MODE = 0,
  localparam int unsigned SW      = (SEL_MODE == 0) ? N : $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*K-1:0] in_bus,
  input  logic [SW-1:0]  sel,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [K-1:0]   out_data,
  output logic           out_err,
  output logic           out_valid,
  input  logic           out_ready,
  input  logic           err_clr,
  output logic           err_sticky,
  output logic [7:0]     err_cnt
);

  localparam int unsigned CNT_W = 8;

  logic [K-1:0] mux_data_c;
  logic         mux_legal_c;
  logic         accept_c;

  // Output register is free when empty or being drained this cycle.
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  generate
    if (SEL_MODE == 0) begin : g_onehot
      // One-hot select: exactly one bit set is legal; anything else yields zero.
      always_comb begin
        mux_data_c  = '0;
        mux_legal_c = $onehot(sel);
        for (int i = 0; i < int'(N); i++) begin
          if (sel[i]) begin
            mux_data_c = mux_data_c | in_bus[i*K +: K];
          end
        end
        if (!mux_legal_c) begin
          mux_data_c = '0;
        end
      end
    end else begin : g_binary
      // Binary select: only codes below N match a channel; others stay zero.
      always_comb begin
        mux_data_c  = '0;
        mux_legal_c = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
          if (sel == SW'(i)) begin
            mux_data_c  = in_bus[i*K +: K];
            mux_legal_c = 1'b1;
          end
        end
      end
    end
  endgenerate

  // Output stage: load on accept, clear valid on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept_c) begin
      out_data  <= mux_data_c;
      out_err   <= !mux_legal_c;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Error bookkeeping: an accepted illegal beat takes priority over err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else if (accept_c && !mux_legal_c) begin
      err_sticky <= 1'b1;
      if (err_clr) begin
        err_cnt <= CNT_W'(1);
      end else if (err_cnt != {CNT_W{1'b1}}) begin
        err_cnt <= err_cnt + CNT_W'(1);
      end
    end else if (err_clr) begin
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end
  end

endmodule
